// File: rtl/tlp2regif_wr.sv
// Receive path for host register writes: decodes MWr32/MWr64 TLPs hitting the register BAR,
// emits a register write strobe, tracks the completion address and raises snd_resp on doorbell.
module tlp2regif_wr #(
    parameter int                BAR_HIT_IDX  = 0,
    parameter int                REG_AW       = 12,
    parameter logic [REG_AW-1:0] CPL_LO_OFF   = 'h000,
    parameter logic [REG_AW-1:0] CPL_HI_OFF   = 'h004,
    parameter logic [REG_AW-1:0] DOORBELL_OFF = 'h008
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       trn_rd,
    input  logic [7:0]        trn_rrem_n,
    input  logic              trn_rsof_n,
    input  logic              trn_reof_n,
    input  logic              trn_rsrc_rdy_n,
    output logic              trn_rdst_rdy_n,
    input  logic [6:0]        trn_rbar_hit_n,
    output logic [63:0]       cpl_addr,
    output logic              snd_resp,
    input  logic              snd_resp_ack,
    output logic              reg_wr,
    output logic [REG_AW-3:0] reg_wr_addr,
    output logic [63:0]       reg_wr_data,
    output logic [1:0]        reg_wr_dwen
);
    localparam int AW = REG_AW - 2;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, COMMIT, DRAIN} state_t;

    state_t        state;
    logic          is4dw, len2, ack_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   dw0, dw1;
    logic          beat, sof, eof, hdr_ok;
    logic [6:0]    fmt_type;
    logic [9:0]    len;
    logic [3:0]    fbe, lbe;
    logic          unused_in;

    assign beat     = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
    assign sof      = !trn_rsof_n;
    assign eof      = !trn_reof_n;
    assign fmt_type = trn_rd[62:56];
    assign len      = trn_rd[41:32];
    assign lbe      = trn_rd[7:4];
    assign fbe      = trn_rd[3:0];
    assign hdr_ok   = (fmt_type == 7'h40 || fmt_type == 7'h60) &&
                      !trn_rbar_hit_n[BAR_HIT_IDX] && fbe == 4'hF &&
                      ((len == 10'd1 && lbe == 4'h0) || (len == 10'd2 && lbe == 4'hF));
    assign unused_in = ^{trn_rrem_n, trn_rd, trn_rbar_hit_n};

    // TLP payload arrives in wire byte order; registers hold host order.
    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            trn_rdst_rdy_n <= 1'b1;
            cpl_addr       <= '0;
            snd_resp       <= 1'b0;
            ack_q          <= 1'b0;
            reg_wr         <= 1'b0;
            reg_wr_addr    <= '0;
            reg_wr_data    <= '0;
            reg_wr_dwen    <= '0;
            is4dw          <= 1'b0;
            len2           <= 1'b0;
            addr_q         <= '0;
            dw0            <= '0;
            dw1            <= '0;
        end else begin
            reg_wr         <= 1'b0;
            ack_q          <= snd_resp_ack;
            // Backpressure mirrors snd_resp; snd_resp=1 only ever holds in IDLE.
            trn_rdst_rdy_n <= snd_resp;
            if (snd_resp && snd_resp_ack && !ack_q) begin
                snd_resp       <= 1'b0;
                trn_rdst_rdy_n <= 1'b0;
            end
            case (state)
                IDLE: if (beat && sof) begin
                    is4dw <= fmt_type[5];
                    len2  <= len[1];
                    dw1   <= '0;
                    if (!eof) state <= hdr_ok ? ADDR : DRAIN;
                end
                ADDR: if (beat) begin
                    if (!is4dw) begin
                        addr_q <= trn_rd[32+REG_AW-1:34];
                        dw0    <= trn_rd[31:0];
                        if (!len2) state <= COMMIT;
                        else       state <= eof ? IDLE : DATA;
                    end else begin
                        addr_q <= trn_rd[REG_AW-1:2];
                        state  <= eof ? IDLE : DATA;
                    end
                end
                DATA: if (beat) begin
                    if (is4dw) begin
                        dw0 <= trn_rd[63:32];
                        if (len2) dw1 <= trn_rd[31:0];
                    end else begin
                        dw1 <= trn_rd[63:32];
                    end
                    state <= COMMIT;
                end
                COMMIT: begin
                    reg_wr      <= 1'b1;
                    reg_wr_addr <= addr_q;
                    reg_wr_data <= {bswap(dw1), bswap(dw0)};
                    reg_wr_dwen <= {len2, 1'b1};
                    if (addr_q == CPL_LO_OFF[REG_AW-1:2]) begin
                        cpl_addr[31:0] <= bswap(dw0);
                        if (len2) cpl_addr[63:32] <= bswap(dw1);
                    end
                    if (addr_q == CPL_HI_OFF[REG_AW-1:2]) cpl_addr[63:32] <= bswap(dw0);
                    if (addr_q == DOORBELL_OFF[REG_AW-1:2]) begin
                        snd_resp       <= 1'b1;
                        trn_rdst_rdy_n <= 1'b1;
                    end
                    state <= IDLE;
                end
                DRAIN: if (beat && eof) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
